// File: rtl/mem_responder_if.sv
// Bus bundle for mem_responder: request/response handshake plus the
// synchronous-RAM port. The requester (master) also models the RAM read data.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] address;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        ready;
  logic        busy;
  logic        addr_err;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  modport master (
    output req, wr, size, address, datain, ram_dout,
    input  dataout, ready, busy, addr_err, ram_addr, ram_wr, ram_din
  );

  modport slave (
    input  req, wr, size, address, datain, ram_dout,
    output dataout, ready, busy, addr_err, ram_addr, ram_wr, ram_din
  );
endinterface

// File: rtl/mem_responder.sv
// Byte/half/word load-store responder in front of a 256x32 synchronous RAM.
// Optional misalignment detection: define MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_r;
  logic        wr_r;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic [31:0] data_r;
  logic [31:0] dataout_r;
  logic        ready_r;
  logic        busy_r;
  logic        addr_err_r;
  logic [7:0]  ram_addr_r;
  logic        ram_wr_r;
  logic [31:0] ram_din_r;
  logic        misalign_s;
  logic        sub_word_s;
  logic        unused_addr_s;

  // Right-aligned, zero-extended lane of a RAM word (size 11 behaves as word).
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
    logic [31:0] res;
    res = 32'd0;
    case (size)
      2'b01: begin
        if (lane[1]) res = {16'd0, word[31:16]};
        else         res = {16'd0, word[15:0]};
      end
      2'b10: begin
        case (lane)
          2'd0:    res = {24'd0, word[7:0]};
          2'd1:    res = {24'd0, word[15:8]};
          2'd2:    res = {24'd0, word[23:16]};
          2'd3:    res = {24'd0, word[31:24]};
          default: res = 32'd0;
        endcase
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of the old word with right-aligned store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    case (size)
      2'b01: begin
        if (lane[1]) res[31:16] = data[15:0];
        else         res[15:0]  = data[15:0];
      end
      2'b10: begin
        case (lane)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          2'd3:    res[31:24] = data[7:0];
          default: res       = word;
        endcase
      end
      default: res = data;
    endcase
    return res;
  endfunction

  // Byte and half stores need a read-modify-write of the containing word.
  always_comb begin
    sub_word_s = 1'b0;
    case (bus.size)
      2'b01:   sub_word_s = 1'b1;
      2'b10:   sub_word_s = 1'b1;
      default: sub_word_s = 1'b0;
    endcase
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  // Misalignment of the request currently presented on the bus.
  always_comb begin
    misalign_s = 1'b0;
    case (bus.size)
      2'b01:   misalign_s = bus.address[0];
      2'b10:   misalign_s = 1'b0;
      default: misalign_s = (bus.address[1:0] != 2'b00);
    endcase
  end
`else
  // Without the check, low address bits are simply ignored where irrelevant.
  assign misalign_s = 1'b0;
`endif

  // Address bits above the 1 KiB window are deliberately ignored.
  assign unused_addr_s = ^bus.address[31:10];

  // Main FSM; every output is a register updated together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      wr_r       <= 1'b0;
      size_r     <= 2'b00;
      lane_r     <= 2'b00;
      data_r     <= 32'd0;
      dataout_r  <= 32'd0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      addr_err_r <= 1'b0;
      ram_addr_r <= 8'd0;
      ram_wr_r   <= 1'b0;
      ram_din_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r    <= 1'b0;
          addr_err_r <= 1'b0;
          ram_wr_r   <= 1'b0;
          if (bus.req) begin
            wr_r   <= bus.wr;
            size_r <= bus.size;
            lane_r <= bus.address[1:0];
            data_r <= bus.datain;
            busy_r <= 1'b1;
            if (misalign_s) begin
              state_r    <= DONE;
              ready_r    <= 1'b1;
              addr_err_r <= 1'b1;
              ram_addr_r <= 8'd0;
            end else if (bus.wr && !sub_word_s) begin
              state_r    <= WR;
              ram_addr_r <= bus.address[9:2];
              ram_wr_r   <= 1'b1;
              ram_din_r  <= bus.datain;
            end else begin
              state_r    <= RD;
              ram_addr_r <= bus.address[9:2];
            end
          end else begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            ram_addr_r <= 8'd0;
          end
        end
        RD: begin
          state_r <= WAIT;
        end
        WAIT: begin
          // RAM data for the word index presented in RD is valid now.
          if (wr_r) begin
            state_r   <= WR;
            ram_wr_r  <= 1'b1;
            ram_din_r <= merge_lane(bus.ram_dout, data_r, size_r, lane_r);
          end else begin
            state_r    <= DONE;
            dataout_r  <= extract_lane(bus.ram_dout, size_r, lane_r);
            ram_addr_r <= 8'd0;
            ready_r    <= 1'b1;
          end
        end
        WR: begin
          state_r    <= DONE;
          ram_wr_r   <= 1'b0;
          ram_din_r  <= 32'd0;
          ram_addr_r <= 8'd0;
          ready_r    <= 1'b1;
        end
        DONE: begin
          state_r    <= IDLE;
          ready_r    <= 1'b0;
          addr_err_r <= 1'b0;
          busy_r     <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          ready_r    <= 1'b0;
          addr_err_r <= 1'b0;
          busy_r     <= 1'b0;
          ram_addr_r <= 8'd0;
          ram_wr_r   <= 1'b0;
          ram_din_r  <= 32'd0;
        end
      endcase
    end
  end

  assign bus.dataout  = dataout_r;
  assign bus.ready    = ready_r;
  assign bus.busy     = busy_r;
  assign bus.addr_err = addr_err_r;
  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_wr   = ram_wr_r;
  assign bus.ram_din  = ram_din_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against an arithmetic model of the load/store rules.
module tb_mem_responder;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  int   wr_pulses;
  logic [7:0]  last_wr_idx;
  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_dout;

  mem_responder_if bus();

  mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: 256x32 synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_wr === 1'b1) begin
      ram[bus.ram_addr] <= bus.ram_din;
      wr_pulses         <= wr_pulses + 1;
      last_wr_idx       <= bus.ram_addr;
    end
    bus.ram_dout <= ram[bus.ram_addr];
  end

  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (sz == 2'd1) return a[0];
    if (sz == 2'd2) return 1'b0;
    return (a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd2) return (w >> (8 * a[1:0])) & 32'h0000_00FF;
    if (sz == 2'd1) return (w >> (16 * a[1])) & 32'h0000_FFFF;
    return w;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd2) begin sh = 8 * a[1:0]; mask = 32'h0000_00FF << sh; end
    else if (sz == 2'd1) begin sh = 16 * a[1]; mask = 32'h0000_FFFF << sh; end
    else begin sh = 0; mask = 32'hFFFF_FFFF; end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Reference model: updates ref_mem / exp_dout and predicts timing and flags.
  task automatic model_op(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic aerr, output int pulses);
    logic [7:0] idx;
    idx = a[9:2];
    if (model_misaligned(sz, a)) begin
      lat = 1; aerr = 1'b1; pulses = 0;
    end else if (!w) begin
      lat = 3; aerr = 1'b0; pulses = 0;
      exp_dout = model_load(ref_mem[idx], sz, a);
    end else begin
      aerr = 1'b0; pulses = 1;
      lat = (sz == 2'd1 || sz == 2'd2) ? 4 : 2;
      ref_mem[idx] = model_store(ref_mem[idx], d, sz, a);
    end
  endtask

  // Issue one request and observe: latency (negedges until Ready), result, flags.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] dout, output logic aerr,
                       output int pulses, output logic [7:0] addr_seen, output logic busy1);
    int p0;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.address = a; bus.datain = d;
    p0 = wr_pulses;
    addr_seen = 8'd0;
    aerr = 1'b0;
    busy1 = 1'b0;
    lat = -1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.wr = 1'($urandom); bus.size = 2'($urandom);
    bus.address = $urandom; bus.datain = $urandom;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = bus.busy;
      addr_seen = addr_seen | bus.ram_addr;
      if (bus.ready === 1'b1) begin
        lat = k;
        aerr = bus.addr_err;
        break;
      end
    end
    @(negedge clk);
    dout = bus.dataout;
    pulses = wr_pulses - p0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.address = 32'd0; bus.datain = 32'd0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({bus.dataout, bus.ready, bus.busy, bus.addr_err, bus.ram_addr, bus.ram_wr, bus.ram_din} !== 75'd0) begin
      $display("FAIL reset_outputs: got dataout=%h ready=%b busy=%b aerr=%b raddr=%h rwr=%b rdin=%h, want all 0",
               bus.dataout, bus.ready, bus.busy, bus.addr_err, bus.ram_addr, bus.ram_wr, bus.ram_din);
    end else pass_cnt++;
    rst = 1'b0;
    exp_dout = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    int lat, pl, elat, ep; logic [31:0] dout; logic aerr, eaerr, b1; logic [7:0] as;
    model_op(1'b1, 2'd0, 32'h10, 32'hDEAD_BEEF, elat, eaerr, ep);
    do_op(1'b1, 2'd0, 32'h10, 32'hDEAD_BEEF, lat, dout, aerr, pl, as, b1);
    total_cnt++; if (lat !== 2) $display("FAIL wstore_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (pl !== 1 || last_wr_idx !== 8'd4) $display("FAIL wstore_pulse: got %0d pulses idx %0d want 1 idx 4", pl, last_wr_idx); else pass_cnt++;
    total_cnt++; if (b1 !== 1'b1) $display("FAIL wstore_busy: got %b want 1", b1); else pass_cnt++;
    model_op(1'b0, 2'd0, 32'h10, 32'd0, elat, eaerr, ep);
    do_op(1'b0, 2'd0, 32'h10, 32'd0, lat, dout, aerr, pl, as, b1);
    total_cnt++; if (lat !== 3) $display("FAIL wload_latency: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (dout !== 32'hDEAD_BEEF) $display("FAIL wload_data: got %h want deadbeef", dout); else pass_cnt++;
    total_cnt++; if (pl !== 0 || aerr !== 1'b0) $display("FAIL wload_side: got pulses %0d aerr %b want 0 0", pl, aerr); else pass_cnt++;
  endtask

  task automatic test_byte_merge();
    int lat, pl, elat, ep; logic [31:0] dout; logic aerr, eaerr, b1; logic [7:0] as;
    model_op(1'b1, 2'd0, 32'h10, 32'h1122_3344, elat, eaerr, ep);
    do_op(1'b1, 2'd0, 32'h10, 32'h1122_3344, lat, dout, aerr, pl, as, b1);
    model_op(1'b1, 2'd2, 32'h12, 32'h0000_00AA, elat, eaerr, ep);
    do_op(1'b1, 2'd2, 32'h12, 32'hFFFF_FFAA, lat, dout, aerr, pl, as, b1);
    total_cnt++; if (lat !== 4) $display("FAIL bstore_latency: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (pl !== 1) $display("FAIL bstore_pulses: got %0d want 1", pl); else pass_cnt++;
    total_cnt++; if (ram[4] !== 32'h11AA_3344) $display("FAIL bstore_ram: got %h want 11aa3344", ram[4]); else pass_cnt++;
    model_op(1'b0, 2'd0, 32'h10, 32'd0, elat, eaerr, ep);
    do_op(1'b0, 2'd0, 32'h10, 32'd0, lat, dout, aerr, pl, as, b1);
    total_cnt++; if (dout !== 32'h11AA_3344) $display("FAIL bstore_readback: got %h want 11aa3344", dout); else pass_cnt++;
  endtask

  task automatic test_sub_loads();
    int lat, pl, elat, ep; logic [31:0] dout; logic aerr, eaerr, b1; logic [7:0] as;
    logic [31:0] addrs [4];
    logic [1:0]  sizes [4];
    logic [31:0] wants [4];
    addrs = '{32'h12, 32'h13, 32'h10, 32'h11};
    sizes = '{2'd1, 2'd2, 2'd1, 2'd2};
    wants = '{32'h0000_1122, 32'h0000_0011, 32'h0000_3344, 32'h0000_0033};
    model_op(1'b1, 2'd0, 32'h10, 32'h1122_3344, elat, eaerr, ep);
    do_op(1'b1, 2'd0, 32'h10, 32'h1122_3344, lat, dout, aerr, pl, as, b1);
    for (int i = 0; i < 4; i++) begin
      model_op(1'b0, sizes[i], addrs[i], 32'd0, elat, eaerr, ep);
      do_op(1'b0, sizes[i], addrs[i], 32'd0, lat, dout, aerr, pl, as, b1);
      total_cnt++;
      if (dout !== wants[i] || lat !== 3)
        $display("FAIL sub_load_%0d: got %h lat %0d want %h lat 3", i, dout, lat, wants[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_req_held();
    int p0, elat, ep; logic eaerr;
    model_op(1'b1, 2'd0, 32'h40, 32'hCAFE_0001, elat, eaerr, ep);
    model_op(1'b1, 2'd0, 32'h40, 32'hCAFE_0001, elat, eaerr, ep);
    @(negedge clk);
    p0 = wr_pulses;
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'd0; bus.address = 32'h40; bus.datain = 32'hCAFE_0001;
    repeat (3) @(negedge clk);
    total_cnt++; if (wr_pulses - p0 !== 1) $display("FAIL held_one_pulse: got %0d want 1", wr_pulses - p0); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL held_idle_gap: got busy %b want 0", bus.busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL held_reaccept: got busy %b want 1", bus.busy); else pass_cnt++;
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (wr_pulses - p0 !== 2) $display("FAIL held_total_pulses: got %0d want 2", wr_pulses - p0); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat, pl, p0, elat, ep; logic [31:0] dout; logic aerr, eaerr, b1; logic [7:0] as;
    model_op(1'b1, 2'd0, 32'h10, 32'h1122_3344, elat, eaerr, ep);
    do_op(1'b1, 2'd0, 32'h10, 32'h1122_3344, lat, dout, aerr, pl, as, b1);
    @(negedge clk);
    p0 = wr_pulses;
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'd2; bus.address = 32'h12; bus.datain = 32'h0000_00AA;
    @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.dataout, bus.ready, bus.busy, bus.addr_err, bus.ram_addr, bus.ram_wr, bus.ram_din} !== 75'd0)
      $display("FAIL abort_outputs: got dataout=%h busy=%b raddr=%h rwr=%b rdin=%h want all 0",
               bus.dataout, bus.busy, bus.ram_addr, bus.ram_wr, bus.ram_din);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_dout = 32'd0;
    repeat (3) @(negedge clk);
    total_cnt++; if (wr_pulses !== p0) $display("FAIL abort_no_write: got %0d pulses want 0", wr_pulses - p0); else pass_cnt++;
    total_cnt++; if (ram[4] !== 32'h1122_3344) $display("FAIL abort_ram: got %h want 11223344", ram[4]); else pass_cnt++;
  endtask

  task automatic test_align();
    int lat, pl, elat, ep; logic [31:0] dout; logic aerr, eaerr, b1; logic [7:0] as;
    model_op(1'b0, 2'd2, 32'h10, 32'd0, elat, eaerr, ep);
    do_op(1'b0, 2'd2, 32'h10, 32'd0, lat, dout, aerr, pl, as, b1);
    model_op(1'b0, 2'd0, 32'h11, 32'd0, elat, eaerr, ep);
    do_op(1'b0, 2'd0, 32'h11, 32'd0, lat, dout, aerr, pl, as, b1);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    total_cnt++; if (lat !== 1 || aerr !== 1'b1) $display("FAIL align_err: got lat %0d aerr %b want 1 1", lat, aerr); else pass_cnt++;
    total_cnt++; if (as !== 8'd0) $display("FAIL align_no_ram: got ram_addr %h want 00", as); else pass_cnt++;
    total_cnt++; if (dout !== 32'h0000_0044) $display("FAIL align_dout_held: got %h want 00000044", dout); else pass_cnt++;
`else
    total_cnt++; if (lat !== 3 || aerr !== 1'b0) $display("FAIL align_ignored: got lat %0d aerr %b want 3 0", lat, aerr); else pass_cnt++;
    total_cnt++; if (as !== 8'd4) $display("FAIL align_index: got ram_addr %h want 04", as); else pass_cnt++;
    total_cnt++; if (dout !== ram[4]) $display("FAIL align_dout: got %h want %h", dout, ram[4]); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    int lat, pl, elat, ep, bad;
    logic [31:0] dout, a, d; logic aerr, eaerr, b1, w; logic [1:0] sz; logic [7:0] as;
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom); sz = 2'($urandom); a = $urandom; d = $urandom;
      a[9:2] = 8'($urandom_range(0, 7));
      model_op(w, sz, a, d, elat, eaerr, ep);
      do_op(w, sz, a, d, lat, dout, aerr, pl, as, b1);
      total_cnt++;
      if (lat !== elat || aerr !== eaerr || pl !== ep || dout !== exp_dout || bus.ram_addr !== 8'd0)
        $display("FAIL rand_%0d: got lat %0d aerr %b pulses %0d dout %h raddr %h want %0d %b %0d %h 00",
                 n, lat, aerr, pl, dout, bus.ram_addr, elat, eaerr, ep, exp_dout);
      else pass_cnt++;
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    total_cnt++; if (bad != 0) $display("FAIL rand_ram_image: got %0d differing words want 0", bad); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    wr_pulses = 0;
    last_wr_idx = 8'd0;
    exp_dout = 32'd0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    test_reset();
    test_word_store_load();
    test_byte_merge();
    test_sub_loads();
    test_req_held();
    test_reset_abort();
    test_align();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
